uart_tx_arbiter: RTL and testbench

Shares the single `uart` 8-character transmitter between several message sources: colour-detect reports, node reports and the end-of-run message. Requesters present a 64-bit ASCII message with a level request. The block grants them round-robin, loads the winner into the transmitter's `str` input, fires a one-cycle `transmit`, waits for `done`, then enforces a minimum inter-message gap. It sits in `top` between the mission sequencer and `uart`, replacing direct `transmit`/`tstr` driving.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_select.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, default timing and the fixed 8-character report messages.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_e;

  localparam int ARB_GAP_CYC_DEF     = 50000;
  localparam int ARB_TIMEOUT_CYC_DEF = 5000000;

  // First character sits in the top byte, matching uart.str.
  localparam logic [63:0] MSG_GBI3_D = "GBI3-D-#";
  localparam logic [63:0] MSG_NODE   = "NODE-01#";
  localparam logic [63:0] MSG_END    = "END-RUN#";

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between message sources, the arbiter and the uart.
// The slave modport is the arbiter's view; master is the requester/uart side.
interface uart_tx_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int MSG_W = 64
);
  logic [NREQ-1:0]       req;
  logic [NREQ*MSG_W-1:0] msg;
  logic [NREQ-1:0]       ack;
  logic [MSG_W-1:0]      tstr;
  logic                  transmit;
  logic                  uart_done;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  timeout_err;

  modport slave (
    input  req, msg, uart_done,
    output ack, tstr, transmit, busy, grant_id, timeout_err
  );

  modport master (
    output req, msg, uart_done,
    input  ack, tstr, transmit, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after the last grant, with wrap.
// Also used by the path-planner request mux, so it carries no state of its own.
module rr_select #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic found_s;
  logic hit_s;
  int   idx_s;

  // Walk the offsets 1..NREQ from the last grant; the first requesting index wins.
  always_comb begin
    gnt_o   = {NREQ{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_s = (int'(last_i) + off) % NREQ;
      for (int k = 0; k < NREQ; k++) begin
        hit_s    = ~found_s & req_i[k] & (k == idx_s);
        gnt_o[k] = gnt_o[k] | hit_s;
        found_s  = found_s | hit_s;
      end
    end
    valid_o = found_s;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the single 8-character uart between several message sources:
// round-robin grant, one-cycle transmit pulse, wait for done edge, then an idle gap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int MSG_W       = 64,
  parameter int GAP_CYC     = ARB_GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEF
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMAX  = {TW{1'b1}};
  // A zero gap still spends one GAP cycle so the FSM always passes through it.
  localparam logic [GW-1:0] GLAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : {GW{1'b0}};

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d, rr_gnt_s;
  logic              rr_valid_s;
  logic [MSG_W-1:0]  tstr_q, tstr_d, msg_sel_s;
  logic              transmit_q, transmit_d;
  logic              busy_q;
  logic              terr_q, terr_d;
  logic              done_q, done_rise_s;
  logic [1:0]        grant_q, grant_d, gidx_s;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;

  rr_select #(.NREQ(NREQ)) u_rr_select (
    .req_i   (bus.req),
    .last_i  (grant_q),
    .gnt_o   (rr_gnt_s),
    .valid_o (rr_valid_s)
  );

  // Encode the one-hot winner and mux its message.
  always_comb begin
    gidx_s    = 2'd0;
    msg_sel_s = {MSG_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      gidx_s    = gidx_s | (rr_gnt_s[k] ? 2'(k) : 2'd0);
      msg_sel_s = msg_sel_s | (rr_gnt_s[k] ? bus.msg[k*MSG_W +: MSG_W] : {MSG_W{1'b0}});
    end
  end

  assign done_rise_s = bus.uart_done & ~done_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ack_d      = {NREQ{1'b0}};
    transmit_d = 1'b0;
    tstr_d     = tstr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    terr_d     = terr_q;
    case (state_q)
      ARB_IDLE: begin
        if (rr_valid_s) begin
          tstr_d  = msg_sel_s;
          ack_d   = rr_gnt_s;
          grant_d = gidx_s;
          state_d = ARB_START;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_START: begin
        transmit_d = 1'b1;
        timer_d    = {TW{1'b0}};
        state_d    = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (done_rise_s) begin
          gap_d   = {GW{1'b0}};
          state_d = ARB_GAP;
        end else if (timer_q >= TLAST) begin
          terr_d  = 1'b1;
          gap_d   = {GW{1'b0}};
          state_d = ARB_GAP;
        end else begin
          timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        end
      end
      ARB_GAP: begin
        if (gap_q >= GLAST) begin
          state_d = ARB_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; busy is precomputed so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ack_q      <= {NREQ{1'b0}};
      transmit_q <= 1'b0;
      tstr_q     <= {MSG_W{1'b0}};
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      grant_q    <= 2'(NREQ - 1);
      timer_q    <= {TW{1'b0}};
      gap_q      <= {GW{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      transmit_q <= transmit_d;
      tstr_q     <= tstr_d;
      busy_q     <= (state_d != ARB_IDLE);
      terr_q     <= terr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      done_q     <= bus.uart_done;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tstr        = tstr_q;
  assign bus.transmit    = transmit_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance A (gap 8, timeout 200) and B (gap 0, timeout 20).
// Expected grants are queued when requests are driven and popped by per-instance ack monitors.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  typedef struct {
    int          id;
    logic [63:0] msg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   last_a;
  int   last_b;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  logic [63:0] msgs [3];

  uart_tx_arbiter_if #(.NREQ(3), .MSG_W(64)) ifa ();
  uart_tx_arbiter_if #(.NREQ(3), .MSG_W(64)) ifb ();

  uart_tx_arbiter #(.NREQ(3), .MSG_W(64), .GAP_CYC(8), .TIMEOUT_CYC(200)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  uart_tx_arbiter #(.NREQ(3), .MSG_W(64), .GAP_CYC(0), .TIMEOUT_CYC(20)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(logic [2:0] req, int last);
    for (int off = 1; off <= 3; off++) begin
      if (((req >> ((last + off) % 3)) & 3'd1) != 3'd0) return (last + off) % 3;
    end
    return -1;
  endfunction

  function automatic exp_t mk_exp(int id);
    exp_t e;
    e.id  = id;
    e.msg = msgs[id];
    return e;
  endfunction

  // Scoreboard for instance A: every ack must match the oldest queued grant.
  always @(negedge clk) begin
    if (ifa.ack != 3'b000) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a unexpected ack=%b expected no ack", ifa.ack);
      end else begin
        ea = qa.pop_front();
        if (ifa.ack !== (3'b001 << ea.id) || ifa.tstr !== ea.msg || ifa.grant_id !== 2'(ea.id)) begin
          errors++;
          $display("FAIL sb_a ack=%b tstr=%h gid=%0d expected id=%0d tstr=%h",
                   ifa.ack, ifa.tstr, ifa.grant_id, ea.id, ea.msg);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (ifb.ack != 3'b000) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL sb_b unexpected ack=%b expected no ack", ifb.ack);
      end else begin
        eb = qb.pop_front();
        if (ifb.ack !== (3'b001 << eb.id) || ifb.tstr !== eb.msg || ifb.grant_id !== 2'(eb.id)) begin
          errors++;
          $display("FAIL sb_b ack=%b tstr=%h gid=%0d expected id=%0d tstr=%h",
                   ifb.ack, ifb.tstr, ifb.grant_id, eb.id, eb.msg);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (ifa.ack !== 3'b000 || ifa.transmit !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl ack=%b transmit=%b busy=%b expected 000/0/0", ifa.ack, ifa.transmit, ifa.busy);
    end
    checks++;
    if (ifa.tstr !== 64'd0 || ifa.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data tstr=%h terr=%b expected 0/0", ifa.tstr, ifa.timeout_err);
    end
    checks++;
    if (ifa.grant_id !== 2'd2 || ifb.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL reset_gid a=%0d b=%0d expected 2", ifa.grant_id, ifb.grant_id);
    end
    rst_n  = 1'b1;
    last_a = 2;
    last_b = 2;
    tick();
  endtask

  task automatic test_single();
    int e;
    e = rr_pick(3'b001, last_a);
    qa.push_back(mk_exp(e));
    last_a = e;
    ifa.req = 3'b001;
    tick();
    checks++;
    if (ifa.ack !== 3'b001 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack ack=%b busy=%b expected 001/1", ifa.ack, ifa.busy);
    end
    ifa.req = 3'b000;
    tick();
    checks++;
    if (ifa.transmit !== 1'b1) begin
      errors++;
      $display("FAIL single_tx transmit=%b expected 1", ifa.transmit);
    end
    tick();
    checks++;
    if (ifa.transmit !== 1'b0 || ifa.busy !== 1'b1 || ifa.tstr !== MSG_GBI3_D) begin
      errors++;
      $display("FAIL single_hold transmit=%b busy=%b tstr=%h expected 0/1/%h",
               ifa.transmit, ifa.busy, ifa.tstr, MSG_GBI3_D);
    end
    repeat (5) tick();
    ifa.uart_done = 1'b1;
    tick();
    ifa.uart_done = 1'b0;
    repeat (7) tick();
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap busy=%b expected 1", ifa.busy);
    end
    tick();
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b expected 0", ifa.busy);
    end
  endtask

  task automatic test_contention();
    int  e;
    bit  seen;
    test_reset();
    ifa.req = 3'b111;
    for (int r = 0; r < 6; r++) begin
      e = rr_pick(3'b111, last_a);
      qa.push_back(mk_exp(e));
      last_a = e;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick();
        seen = (ifa.ack != 3'b000);
      end
      checks++;
      if (!seen || e != r % 3) begin
        errors++;
        $display("FAIL cont_ack round=%0d seen=%b model=%0d expected grant %0d", r, seen, e, r % 3);
      end
      ifa.req = 3'b111 & ~(3'b001 << e);
      tick();
      ifa.req = (r == 5) ? 3'b000 : 3'b111;
      checks++;
      if (ifa.transmit !== 1'b1) begin
        errors++;
        $display("FAIL cont_tx round=%0d transmit=%b expected 1", r, ifa.transmit);
      end
      repeat (100) tick();
      ifa.uart_done = 1'b1;
      tick();
      ifa.uart_done = 1'b0;
    end
    repeat (12) tick();
  endtask

  task automatic test_stale_done();
    int e;
    bit seen;
    ifa.uart_done = 1'b1;
    tick();
    e = rr_pick(3'b010, last_a);
    qa.push_back(mk_exp(e));
    last_a = e;
    ifa.req = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (ifa.ack != 3'b000);
    end
    ifa.req = 3'b000;
    tick();
    checks++;
    if (!seen || ifa.transmit !== 1'b1) begin
      errors++;
      $display("FAIL stale_start seen=%b transmit=%b expected 1/1", seen, ifa.transmit);
    end
    repeat (20) tick();
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold busy=%b expected 1", ifa.busy);
    end
    ifa.uart_done = 1'b0;
    tick();
    ifa.uart_done = 1'b1;
    tick();
    repeat (7) tick();
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_gap busy=%b expected 1", ifa.busy);
    end
    tick();
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_idle busy=%b expected 0", ifa.busy);
    end
    ifa.uart_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int e;
    bit seen;
    e = rr_pick(3'b001, last_b);
    qb.push_back(mk_exp(e));
    last_b = e;
    ifb.req = 3'b001;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (ifb.ack != 3'b000);
    end
    ifb.req = 3'b000;
    tick();
    checks++;
    if (!seen || ifb.transmit !== 1'b1) begin
      errors++;
      $display("FAIL to_start seen=%b transmit=%b expected 1/1", seen, ifb.transmit);
    end
    repeat (19) tick();
    checks++;
    if (ifb.timeout_err !== 1'b0 || ifb.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early terr=%b busy=%b expected 0/1", ifb.timeout_err, ifb.busy);
    end
    tick();
    checks++;
    if (ifb.timeout_err !== 1'b1 || ifb.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_set terr=%b busy=%b expected 1/1", ifb.timeout_err, ifb.busy);
    end
    tick();
    checks++;
    if (ifb.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_idle busy=%b expected 0", ifb.busy);
    end
    e = rr_pick(3'b010, last_b);
    qb.push_back(mk_exp(e));
    last_b = e;
    ifb.req = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (ifb.ack != 3'b000);
    end
    ifb.req = 3'b000;
    checks++;
    if (!seen || ifb.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_next seen=%b terr=%b expected 1/1", seen, ifb.timeout_err);
    end
    repeat (3) tick();
    ifb.uart_done = 1'b1;
    tick();
    ifb.uart_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gap0();
    int e;
    bit seen;
    e = rr_pick(3'b011, last_b);
    qb.push_back(mk_exp(e));
    last_b = e;
    ifb.req = 3'b011;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (ifb.ack != 3'b000);
    end
    ifb.req = 3'b010;
    e = rr_pick(3'b010, last_b);
    qb.push_back(mk_exp(e));
    last_b = e;
    repeat (3) tick();
    ifb.uart_done = 1'b1;
    tick();
    ifb.uart_done = 1'b0;
    checks++;
    if (!seen || ifb.busy !== 1'b1) begin
      errors++;
      $display("FAIL gap0_gap seen=%b busy=%b expected 1/1", seen, ifb.busy);
    end
    tick();
    checks++;
    if (ifb.busy !== 1'b0 || ifb.ack !== 3'b000) begin
      errors++;
      $display("FAIL gap0_idle busy=%b ack=%b expected 0/000", ifb.busy, ifb.ack);
    end
    tick();
    checks++;
    if (ifb.ack !== 3'b010) begin
      errors++;
      $display("FAIL gap0_ack ack=%b expected 010", ifb.ack);
    end
    ifb.req = 3'b000;
    repeat (3) tick();
    ifb.uart_done = 1'b1;
    tick();
    ifb.uart_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int e;
    e = rr_pick(3'b001, last_a);
    qa.push_back(mk_exp(e));
    last_a = e;
    ifa.req = 3'b001;
    tick();
    ifa.req = 3'b000;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    last_a = 2;
    last_b = 2;
    checks++;
    if (ifa.ack !== 3'b000 || ifa.transmit !== 1'b0 || ifa.busy !== 1'b0 || ifa.tstr !== 64'd0) begin
      errors++;
      $display("FAIL rmid_out ack=%b tx=%b busy=%b tstr=%h expected reset values",
               ifa.ack, ifa.transmit, ifa.busy, ifa.tstr);
    end
    checks++;
    if (ifa.grant_id !== 2'd2 || ifb.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_state gid=%0d terr_b=%b expected 2/0", ifa.grant_id, ifb.timeout_err);
    end
    ifa.uart_done = 1'b1;
    tick();
    ifa.uart_done = 1'b0;
    tick();
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_done busy=%b expected 0", ifa.busy);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    last_a  = 2;
    last_b  = 2;
    msgs[0] = MSG_GBI3_D;
    msgs[1] = MSG_NODE;
    msgs[2] = MSG_END;
    rst_n   = 1'b0;
    ifa.req = 3'b000;
    ifb.req = 3'b000;
    ifa.uart_done = 1'b0;
    ifb.uart_done = 1'b0;
    ifa.msg = {MSG_END, MSG_NODE, MSG_GBI3_D};
    ifb.msg = {MSG_END, MSG_NODE, MSG_GBI3_D};

    test_reset();
    test_single();
    test_contention();
    test_stale_done();
    test_timeout();
    test_gap0();
    test_reset_mid();

    repeat (5) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending_a=%0d pending_b=%0d expected 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
